// File: rtl/stream_to_tensor.sv
// Packs a channel-major stream of WIDTH-bit elements into one flat CH*H*W tensor vector.
// Define STREAM_TO_TENSOR_PINGPONG_EN for a second bank so capture overlaps with hold.
module stream_to_tensor #(
    parameter int CH        = 1,
    parameter int H         = 1,
    parameter int W         = 1,
    parameter int WIDTH     = 16,
    parameter     PRECISION = "Q8.8"
) (
    input  logic                              clk,
    input  logic                              rst_n,
    input  logic                              in_valid,
    output logic                              in_ready,
    input  logic signed [WIDTH-1:0]           in_data,
    input  logic                              in_last,
    output logic                              out_valid,
    input  logic                              out_ready,
    output logic signed [CH*H*W*WIDTH-1:0]    out_vec,
    output logic                              err_frame
);

    localparam int N     = CH * H * W;
    localparam int CNT_W = (N > 1) ? $clog2(N) : 1;
    localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(N - 1);

    // The format tag travels with the instance for downstream bookkeeping only.
    if ($bits(PRECISION) == 0) begin : g_untagged
    end

    logic [CNT_W-1:0] count_r;
    logic             err_frame_r;
    logic             in_ready_r;
    logic             out_valid_r;
    logic             accept_s;
    logic             last_beat_s;

    // Handshake decode for the input side.
    always_comb begin
        accept_s    = in_valid && in_ready_r;
        last_beat_s = accept_s && (count_r == LAST_IDX);
    end

    // Element counter: position of the next element inside the tensor.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_r <= '0;
        end else if (accept_s) begin
            if (count_r == LAST_IDX) begin
                count_r <= '0;
            end else begin
                count_r <= count_r + CNT_W'(1);
            end
        end else begin
            count_r <= count_r;
        end
    end

    // Sticky framing check; the tensor still completes on count alone.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_frame_r <= 1'b0;
        end else if (accept_s && (in_last != (count_r == LAST_IDX))) begin
            err_frame_r <= 1'b1;
        end else begin
            err_frame_r <= err_frame_r;
        end
    end

`ifdef STREAM_TO_TENSOR_PINGPONG_EN

    logic [N*WIDTH-1:0] bank_r [2];
    logic [1:0]         full_r;
    logic [1:0]         full_n_s;
    logic               wb_r;
    logic               rb_r;
    logic               wb_n_s;
    logic               rb_n_s;
    logic               take_s;
    logic [N*WIDTH-1:0] out_vec_s;

    // Element capture into the bank currently being filled.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bank_r[0] <= '0;
            bank_r[1] <= '0;
        end else if (accept_s) begin
            bank_r[wb_r][count_r*WIDTH +: WIDTH] <= in_data;
        end else begin
            bank_r[0] <= bank_r[0];
            bank_r[1] <= bank_r[1];
        end
    end

    // Next bank flags/pointers; fill-complete and drain may coincide on different banks.
    always_comb begin
        take_s   = out_valid_r && out_ready;
        full_n_s = full_r;
        wb_n_s   = wb_r;
        rb_n_s   = rb_r;
        if (take_s) begin
            full_n_s[rb_r] = 1'b0;
            rb_n_s         = ~rb_r;
        end else begin
            rb_n_s         = rb_r;
        end
        if (last_beat_s) begin
            full_n_s[wb_r] = 1'b1;
            wb_n_s         = ~wb_r;
        end else begin
            wb_n_s         = wb_r;
        end
    end

    // Bank state registers with handshake outputs registered from next state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            full_r      <= 2'b00;
            wb_r        <= 1'b0;
            rb_r        <= 1'b0;
            in_ready_r  <= 1'b1;
            out_valid_r <= 1'b0;
        end else begin
            full_r      <= full_n_s;
            wb_r        <= wb_n_s;
            rb_r        <= rb_n_s;
            in_ready_r  <= ~full_n_s[wb_n_s];
            out_valid_r <= full_n_s[rb_n_s];
        end
    end

    // Read-bank select for the presented tensor.
    always_comb begin
        if (rb_r) begin
            out_vec_s = bank_r[1];
        end else begin
            out_vec_s = bank_r[0];
        end
    end

    assign out_vec = out_vec_s;

`else

    typedef enum logic [0:0] {
        ST_FILL = 1'b0,
        ST_HOLD = 1'b1
    } state_t;

    state_t             state_r;
    logic [N*WIDTH-1:0] bank_r;

    // Element capture; writes only happen in FILL, so the held tensor never moves.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bank_r <= '0;
        end else if (accept_s) begin
            bank_r[count_r*WIDTH +: WIDTH] <= in_data;
        end else begin
            bank_r <= bank_r;
        end
    end

    // FILL/HOLD controller with registered handshake outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r     <= ST_FILL;
            in_ready_r  <= 1'b1;
            out_valid_r <= 1'b0;
        end else begin
            case (state_r)
                ST_FILL: begin
                    if (last_beat_s) begin
                        state_r     <= ST_HOLD;
                        in_ready_r  <= 1'b0;
                        out_valid_r <= 1'b1;
                    end else begin
                        state_r     <= ST_FILL;
                        in_ready_r  <= 1'b1;
                        out_valid_r <= 1'b0;
                    end
                end
                ST_HOLD: begin
                    if (out_ready) begin
                        state_r     <= ST_FILL;
                        in_ready_r  <= 1'b1;
                        out_valid_r <= 1'b0;
                    end else begin
                        state_r     <= ST_HOLD;
                        in_ready_r  <= 1'b0;
                        out_valid_r <= 1'b1;
                    end
                end
                default: begin
                    state_r     <= ST_FILL;
                    in_ready_r  <= 1'b1;
                    out_valid_r <= 1'b0;
                end
            endcase
        end
    end

    assign out_vec = bank_r;

`endif

    assign in_ready  = in_ready_r;
    assign out_valid = out_valid_r;
    assign err_frame = err_frame_r;

endmodule

// File: tb/tb_stream_to_tensor.sv
// Directed bench for stream_to_tensor: table-driven beats plus hand-written hold, rate and reset sequences.
module tb_stream_to_tensor;

`ifdef STREAM_TO_TENSOR_PINGPONG_EN
    localparam bit PP = 1'b1;
`else
    localparam bit PP = 1'b0;
`endif

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic               rst_n;
    logic               a_in_valid, a_in_ready, a_in_last, a_out_valid, a_out_ready, a_err;
    logic signed [15:0] a_in_data;
    logic signed [63:0] a_out_vec;
    logic               b_in_valid, b_in_ready, b_in_last, b_out_valid, b_out_ready, b_err;
    logic signed [7:0]  b_in_data;
    logic signed [47:0] b_out_vec;

    stream_to_tensor #(.CH(1), .H(2), .W(2), .WIDTH(16)) dut_a (
        .clk(clk), .rst_n(rst_n),
        .in_valid(a_in_valid), .in_ready(a_in_ready), .in_data(a_in_data), .in_last(a_in_last),
        .out_valid(a_out_valid), .out_ready(a_out_ready), .out_vec(a_out_vec), .err_frame(a_err)
    );

    stream_to_tensor #(.CH(2), .H(1), .W(3), .WIDTH(8)) dut_b (
        .clk(clk), .rst_n(rst_n),
        .in_valid(b_in_valid), .in_ready(b_in_ready), .in_data(b_in_data), .in_last(b_in_last),
        .out_valid(b_out_valid), .out_ready(b_out_ready), .out_vec(b_out_vec), .err_frame(b_err)
    );

    typedef struct {
        logic        v;
        logic [15:0] d;
        logic        l;
        logic        r;
        logic        ir;
        logic        ov;
        logic        cv;
        logic [63:0] vec;
        logic        err;
    } row_t;

    row_t tbl [13];
    int   checks = 0;
    int   errors = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: actual=%h expected=%h", name, act, exp);
        end
    endtask

    task automatic tick;
        @(negedge clk);
    endtask

    task automatic drive_a(input logic v, input logic [15:0] d, input logic l, input logic r);
        a_in_valid  = v;
        a_in_data   = d;
        a_in_last   = l;
        a_out_ready = r;
    endtask

    function automatic row_t mk(input logic v, input logic [15:0] d, input logic l, input logic r,
                                input logic ir, input logic ov, input logic cv,
                                input logic [63:0] vec, input logic err);
        row_t x;
        x.v = v; x.d = d; x.l = l; x.r = r; x.ir = ir; x.ov = ov; x.cv = cv; x.vec = vec; x.err = err;
        return x;
    endfunction

    initial begin
        #100000;
        $display("FAIL watchdog: actual=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int idx;
        int ncap;
        int drops;
        int last_acc;
        logic [63:0] caps [3];

        // Basic tensor with immediate drain, then a framing error on element 1.
        tbl[0]  = mk(1'b1, 16'h0001, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 64'h0, 1'b0);
        tbl[1]  = mk(1'b1, 16'h0002, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 64'h0, 1'b0);
        tbl[2]  = mk(1'b1, 16'h0003, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 64'h0, 1'b0);
        tbl[3]  = mk(1'b1, 16'h0004, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 64'h0, 1'b0);
        tbl[4]  = mk(1'b0, 16'h0000, 1'b0, 1'b1, PP,   1'b1, 1'b1, 64'h0004_0003_0002_0001, 1'b0);
        tbl[5]  = mk(1'b0, 16'h0000, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 64'h0, 1'b0);
        tbl[6]  = mk(1'b1, 16'h0041, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 64'h0, 1'b0);
        tbl[7]  = mk(1'b1, 16'h0042, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 64'h0, 1'b0);
        tbl[8]  = mk(1'b1, 16'h0043, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 64'h0, 1'b1);
        tbl[9]  = mk(1'b1, 16'h0044, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 64'h0, 1'b1);
        tbl[10] = mk(1'b0, 16'h0000, 1'b0, 1'b0, PP,   1'b1, 1'b1, 64'h0044_0043_0042_0041, 1'b1);
        tbl[11] = mk(1'b0, 16'h0000, 1'b0, 1'b1, PP,   1'b1, 1'b1, 64'h0044_0043_0042_0041, 1'b1);
        tbl[12] = mk(1'b0, 16'h0000, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 64'h0, 1'b1);

        rst_n = 1'b0;
        drive_a(1'b0, 16'h0000, 1'b0, 1'b0);
        b_in_valid = 1'b0; b_in_data = 8'h00; b_in_last = 1'b0; b_out_ready = 1'b0;
        repeat (3) tick();
        rst_n = 1'b1;

        for (int i = 0; i < 13; i++) begin
            check($sformatf("row%0d_in_ready", i), {63'h0, a_in_ready}, {63'h0, tbl[i].ir});
            check($sformatf("row%0d_out_valid", i), {63'h0, a_out_valid}, {63'h0, tbl[i].ov});
            check($sformatf("row%0d_err_frame", i), {63'h0, a_err}, {63'h0, tbl[i].err});
            if (tbl[i].cv) begin
                check($sformatf("row%0d_out_vec", i), a_out_vec, tbl[i].vec);
            end
            drive_a(tbl[i].v, tbl[i].d, tbl[i].l, tbl[i].r);
            tick();
        end

        // Reset mid-tensor discards the partial data and clears the sticky error.
        drive_a(1'b1, 16'h00EE, 1'b0, 1'b0);
        tick();
        drive_a(1'b1, 16'h00EF, 1'b0, 1'b0);
        tick();
        drive_a(1'b0, 16'h0000, 1'b0, 1'b0);
        rst_n = 1'b0;
        #1;
        check("rst_in_ready", {63'h0, a_in_ready}, 64'h1);
        check("rst_out_valid", {63'h0, a_out_valid}, 64'h0);
        check("rst_out_vec", a_out_vec, 64'h0);
        check("rst_err_frame", {63'h0, a_err}, 64'h0);
        tick();
        rst_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            drive_a(1'b1, 16'h00A0 + 16'(i), (i == 3), 1'b0);
            tick();
        end
        drive_a(1'b0, 16'h0000, 1'b0, 1'b0);
        check("post_rst_out_valid", {63'h0, a_out_valid}, 64'h1);
        check("post_rst_out_vec", a_out_vec, 64'h00A3_00A2_00A1_00A0);
        check("post_rst_err_frame", {63'h0, a_err}, 64'h0);
        drive_a(1'b0, 16'h0000, 1'b0, 1'b1);
        tick();
        check("post_rst_drained", {63'h0, a_out_valid}, 64'h0);

        // Consumer stalls for 10 cycles while a second tensor is offered.
        for (int i = 0; i < 4; i++) begin
            drive_a(1'b1, 16'h0005 + 16'(i), (i == 3), 1'b0);
            tick();
        end
        idx = 0;
        for (int j = 0; j < 10; j++) begin
            check($sformatf("hold%0d_out_valid", j), {63'h0, a_out_valid}, 64'h1);
            check($sformatf("hold%0d_out_vec", j), a_out_vec, 64'h0008_0007_0006_0005);
            check($sformatf("hold%0d_in_ready", j), {63'h0, a_in_ready}, {63'h0, (PP && (j < 4))});
            if (idx < 4) begin
                drive_a(1'b1, 16'h0011 + 16'(idx), (idx == 3), 1'b0);
            end else begin
                drive_a(1'b0, 16'h0000, 1'b0, 1'b0);
            end
            if (a_in_ready && idx < 4) idx++;
            tick();
        end
        drive_a(1'b0, 16'h0000, 1'b0, 1'b1);
        tick();
        check("after_hold_out_valid", {63'h0, a_out_valid}, {63'h0, PP});
        check("after_hold_in_ready", {63'h0, a_in_ready}, 64'h1);
        if (PP) check("second_tensor_vec", a_out_vec, 64'h0014_0013_0012_0011);
        tick();
        check("after_hold_drained", {63'h0, a_out_valid}, 64'h0);
        drive_a(1'b0, 16'h0000, 1'b0, 1'b0);
        tick();

        // Three back-to-back tensors with input and output always willing.
        idx = 0; ncap = 0; drops = 0; last_acc = -1;
        for (int c = 0; c < 40; c++) begin
            if (a_out_valid && ncap < 3) begin
                caps[ncap] = a_out_vec;
                ncap++;
            end
            if (idx == 12 && ncap == 3) break;
            if (idx < 12) begin
                drive_a(1'b1, 16'h0030 + 16'(idx), (idx % 4 == 3), 1'b1);
                if (!a_in_ready) drops++;
                if (a_in_ready) begin
                    last_acc = c;
                    idx++;
                end
            end else begin
                drive_a(1'b0, 16'h0000, 1'b0, 1'b1);
            end
            tick();
        end
        tick();
        drive_a(1'b0, 16'h0000, 1'b0, 1'b0);
        check("b2b_accepts", 64'(idx), 64'd12);
        check("b2b_transfers", 64'(ncap), 64'd3);
        check("b2b_ready_drops", 64'(drops), PP ? 64'd0 : 64'd2);
        check("b2b_last_accept_cycle", 64'(last_acc), PP ? 64'd11 : 64'd13);
        if (ncap == 3) begin
            check("b2b_tensor0", caps[0], 64'h0033_0032_0031_0030);
            check("b2b_tensor1", caps[1], 64'h0037_0036_0035_0034);
            check("b2b_tensor2", caps[2], 64'h003B_003A_0039_0038);
        end
        check("b2b_err_frame", {63'h0, a_err}, 64'h0);

        // Second configuration: CH=2,H=1,W=3 bytes.
        for (int k = 0; k < 6; k++) begin
            b_in_valid = 1'b1; b_in_data = 8'(k); b_in_last = (k == 5); b_out_ready = 1'b1;
            if (k == 5) check("b_pre_out_valid", {63'h0, b_out_valid}, 64'h0);
            tick();
        end
        b_in_valid = 1'b0; b_in_last = 1'b0;
        check("b_out_valid", {63'h0, b_out_valid}, 64'h1);
        check("b_out_vec", {16'h0, b_out_vec}, 64'h0000_0504_0302_0100);
        check("b_err_frame", {63'h0, b_err}, 64'h0);
        tick();
        check("b_drained", {63'h0, b_out_valid}, 64'h0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
